// File: rtl/sram_word_cell_pkg.sv
// Shared types and defaults for the SRAM word array.
// Parity storage is enabled by defining SRADDR_PARITY_EN.
package sram_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 7;
    localparam int NUM_WORDS = 128;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t RESET_VAL = '0;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/sram_word_cell_if.sv
// Per-word command/data bundle between the array and one storage word.
// The parity_err/inject_err signals exist only when SRADDR_PARITY_EN is defined.
interface sram_word_cell_if #(
    parameter int DATA_W = sram_pkg::DATA_W
);
    logic              WL;
    logic              read_pulse;
    logic              write_pulse;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              rd_valid;
`ifdef SRADDR_PARITY_EN
    logic              inject_err;
    logic              parity_err;
`endif

    modport master (
`ifdef SRADDR_PARITY_EN
        output inject_err,
        input  parity_err,
`endif
        output WL,
        output read_pulse,
        output write_pulse,
        output datain,
        input  dataout,
        input  rd_valid
    );

    modport slave (
`ifdef SRADDR_PARITY_EN
        input  inject_err,
        output parity_err,
`endif
        input  WL,
        input  read_pulse,
        input  write_pulse,
        input  datain,
        output dataout,
        output rd_valid
    );

endinterface

// File: rtl/sram_word_cell_pulse_rise_det.sv
// Rising-edge detector for a level command pulse, sampled on clk.
// A pulse that is already high while reset is applied never produces a rise.
module pulse_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q, in_d;
    logic armed_q, armed_d;

    always_comb begin
        in_d    = in;
        armed_d = armed_q | ~in;
    end

    assign rise = in & ~in_q & armed_q;

    // armed_q only arms once the input has been seen low, so a level that
    // stays high across reset release is not mistaken for a new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= 1'b0;
            armed_q <= ~in;
        end else begin
            in_q    <= in_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sram_word_cell.sv
// One addressable storage word with edge-detected read/write commands.
// Optional even-parity protection is built when SRADDR_PARITY_EN is defined.
module sram_word_cell #(
    parameter int                        DATA_W    = sram_pkg::DATA_W,
    parameter logic [sram_pkg::DATA_W-1:0] RESET_VAL = sram_pkg::RESET_VAL
) (
    input  logic             clk,
    input  logic             rst,
    sram_word_cell_if.slave  bus
);
    import sram_pkg::*;

    word_t word_q, word_d;
    word_t dataout_q, dataout_d;
    logic  rd_valid_q, rd_valid_d;
    logic  rd_rise, wr_rise;
    logic  rd_sel, wr_sel;

    pulse_rise_det u_rd_det (
        .clk  (clk),
        .rst  (rst),
        .in   (bus.read_pulse),
        .rise (rd_rise)
    );

    pulse_rise_det u_wr_det (
        .clk  (clk),
        .rst  (rst),
        .in   (bus.write_pulse),
        .rise (wr_rise)
    );

    assign rd_sel = rd_rise & bus.WL;
    assign wr_sel = wr_rise & bus.WL;

`ifdef SRADDR_PARITY_EN
    logic parity_q, parity_d;
    logic parity_err_q, parity_err_d;
`endif

    // Read samples word_q before the write lands, giving read-before-write.
    always_comb begin
        word_d     = word_q;
        dataout_d  = dataout_q;
        rd_valid_d = 1'b0;
`ifdef SRADDR_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = parity_err_q;
`endif
        if (rd_sel) begin
            dataout_d  = word_q;
            rd_valid_d = 1'b1;
`ifdef SRADDR_PARITY_EN
            parity_err_d = even_parity(word_q) ^ parity_q;
`endif
        end
        if (wr_sel) begin
            word_d = bus.datain;
`ifdef SRADDR_PARITY_EN
            parity_d = even_parity(bus.datain) ^ bus.inject_err;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= RESET_VAL;
            dataout_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef SRADDR_PARITY_EN
            parity_q     <= even_parity(RESET_VAL);
            parity_err_q <= 1'b0;
`endif
        end else begin
            word_q     <= word_d;
            dataout_q  <= dataout_d;
            rd_valid_q <= rd_valid_d;
`ifdef SRADDR_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.dataout  = dataout_q;
    assign bus.rd_valid = rd_valid_q;
`ifdef SRADDR_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sram_word_cell.sv
// Directed self-checking bench for sram_word_cell.
// Parity checks are included when SRADDR_PARITY_EN is defined.
module tb_sram_word_cell;
    import sram_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sram_word_cell_if #(.DATA_W(DATA_W)) bus ();

    sram_word_cell #(.DATA_W(DATA_W), .RESET_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd_cmd();
        bus.read_pulse = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst              = 1'b1;
        bus.WL           = 1'b0;
        bus.read_pulse   = 1'b0;
        bus.write_pulse  = 1'b0;
        bus.datain       = '0;
`ifdef SRADDR_PARITY_EN
        bus.inject_err   = 1'b0;
`endif
        step();
        step();
        chk("reset_dataout", bus.dataout, 32'h0);
        chk("reset_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
        rst = 1'b0;
        step();

        // read after reset
        bus.WL = 1'b1;
        rd_cmd();
        chk("rst_read_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("rst_read_data", bus.dataout, 32'h0);
        bus.read_pulse = 1'b0;
        step();
        chk("rst_read_valid_drop", {31'b0, bus.rd_valid}, 32'h0);

        // write then read
        bus.datain = 32'hDEADBEEF;
        bus.write_pulse = 1'b1;
        step();
        bus.write_pulse = 1'b0;
        step();
        rd_cmd();
        chk("wr_rd_data", bus.dataout, 32'hDEADBEEF);
        chk("wr_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
        step();
        chk("wr_rd_valid_one_cycle", {31'b0, bus.rd_valid}, 32'h0);
        bus.read_pulse = 1'b0;
        step();

        // unselected commands ignored
        bus.WL = 1'b0;
        bus.datain = 32'h12345678;
        bus.write_pulse = 1'b1;
        step();
        bus.write_pulse = 1'b0;
        step();
        rd_cmd();
        chk("unsel_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("unsel_dataout_hold", bus.dataout, 32'hDEADBEEF);
        bus.read_pulse = 1'b0;
        step();
        bus.WL = 1'b1;
        rd_cmd();
        chk("reselect_data", bus.dataout, 32'hDEADBEEF);
        chk("reselect_valid", {31'b0, bus.rd_valid}, 32'h1);
        bus.read_pulse = 1'b0;
        step();

        // simultaneous read/write: read-before-write
        bus.datain = 32'hA5A5A5A5;
        bus.write_pulse = 1'b1;
        step();
        bus.write_pulse = 1'b0;
        step();
        bus.datain = 32'h5A5A5A5A;
        bus.write_pulse = 1'b1;
        bus.read_pulse = 1'b1;
        step();
        chk("rbw_old_data", bus.dataout, 32'hA5A5A5A5);
        bus.write_pulse = 1'b0;
        bus.read_pulse = 1'b0;
        step();
        rd_cmd();
        chk("rbw_new_data", bus.dataout, 32'h5A5A5A5A);
        bus.read_pulse = 1'b0;
        step();

        // held write pulse is one command
        bus.write_pulse = 1'b1;
        bus.datain = 32'h1; step();
        bus.datain = 32'h2; step();
        bus.datain = 32'h3; step();
        step();
        step();
        bus.write_pulse = 1'b0;
        step();
        rd_cmd();
        chk("held_write_data", bus.dataout, 32'h1);
        bus.read_pulse = 1'b0;
        step();

        // WL change while read pulse stays high
        bus.WL = 1'b0;
        rd_cmd();
        bus.WL = 1'b1;
        step();
        chk("wl_late_no_read", {31'b0, bus.rd_valid}, 32'h0);
        bus.read_pulse = 1'b0;
        step();

        // pulse high through reset is not a command
        bus.read_pulse = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("rst_hold_dataout", bus.dataout, 32'h0);
        rst = 1'b0;
        step();
        chk("rst_release_no_read", {31'b0, bus.rd_valid}, 32'h0);
        step();
        chk("rst_release_no_read2", {31'b0, bus.rd_valid}, 32'h0);
        chk("rst_release_dataout", bus.dataout, 32'h0);
        bus.read_pulse = 1'b0;
        step();
        rd_cmd();
        chk("post_rst_read_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("post_rst_read_data", bus.dataout, 32'h0);
        bus.read_pulse = 1'b0;
        step();

`ifdef SRADDR_PARITY_EN
        bus.datain = 32'h00000001;
        bus.inject_err = 1'b1;
        bus.write_pulse = 1'b1;
        step();
        bus.write_pulse = 1'b0;
        bus.inject_err = 1'b0;
        step();
        rd_cmd();
        chk("parity_err_injected", {31'b0, bus.parity_err}, 32'h1);
        bus.read_pulse = 1'b0;
        step();
        bus.write_pulse = 1'b1;
        step();
        bus.write_pulse = 1'b0;
        step();
        rd_cmd();
        chk("parity_err_clean", {31'b0, bus.parity_err}, 32'h0);
        chk("parity_data", bus.dataout, 32'h1);
        bus.read_pulse = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
